// File: rtl/alu_seq_mext_if.sv
// Request/response bundle between the pipeline and the execute-stage ALU.
// The pipeline drives the master modport and the ALU implements the slave modport.
interface alu_seq_mext_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [6:0]      opcode;
   logic [2:0]      func3;
   logic [6:0]      func7;
   logic [XLEN-1:0] operand1;
   logic [XLEN-1:0] operand2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_out;
   logic            non_operation;
   logic            busy;

   modport master (
      output flush, in_valid, opcode, func3, func7, operand1, operand2, out_ready,
      input  in_ready, out_valid, alu_out, non_operation, busy
   );

   modport slave (
      input  flush, in_valid, opcode, func3, func7, operand1, operand2, out_ready,
      output in_ready, out_valid, alu_out, non_operation, busy
   );
endinterface

// File: rtl/alu_seq_mext.sv
// RV32I execute-stage ALU with iterative RV32M multiply/divide behind a valid/ready handshake.
// Base ops and M corner cases finish in one cycle; other M ops spend XLEN cycles in BUSY.
module alu_seq_mext #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_mext_if.slave bus
);
   localparam int SH_W = $clog2(XLEN);

   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_B     = 7'b1100011;
   localparam logic [6:0] OPC_L     = 7'b0000011;
   localparam logic [6:0] OPC_S     = 7'b0100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [XLEN-1:0] ZERO_W     = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ONES_W     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_W      = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] LOW12_MASK = XLEN'(32'h0000_0FFF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [XLEN-1:0] as_word(input logic bit_v);
      return {{(XLEN-1){1'b0}}, bit_v};
   endfunction

   // Single-cycle result of every non-M encoding; unknown encodings yield zero
   function automatic logic [XLEN-1:0] base_result(
      input logic [6:0]      opc,
      input logic [2:0]      f3,
      input logic [6:0]      f7,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
   );
      logic [XLEN-1:0] r;
      logic [SH_W-1:0] sh;
      logic            std;
      logic            alt;
      logic            imm;
      r   = ZERO_W;
      sh  = b[SH_W-1:0];
      std = (f7 == F7_BASE);
      alt = (f7 == F7_ALT);
      imm = (opc == OPC_I);
      case (opc)
         OPC_R, OPC_I: begin
            case (f3)
               3'b000:  r = (imm || std) ? a + b : (alt ? a - b : ZERO_W);
               3'b001:  r = std ? a << sh : ZERO_W;
               3'b010:  r = (imm || std) ? as_word($signed(a) < $signed(b)) : ZERO_W;
               3'b011:  r = (imm || std) ? as_word(a < b) : ZERO_W;
               3'b100:  r = (imm || std) ? a ^ b : ZERO_W;
               3'b101:  r = std ? a >> sh : (alt ? XLEN'($signed(a) >>> sh) : ZERO_W);
               3'b110:  r = (imm || std) ? a | b : ZERO_W;
               3'b111:  r = (imm || std) ? a & b : ZERO_W;
               default: r = ZERO_W;
            endcase
         end
         OPC_B: begin
            case (f3)
               3'b000:  r = as_word(a == b);
               3'b001:  r = as_word(a != b);
               3'b100:  r = as_word($signed(a) < $signed(b));
               3'b101:  r = as_word($signed(a) >= $signed(b));
               3'b110:  r = as_word(a < b);
               3'b111:  r = as_word(a >= b);
               default: r = ZERO_W;
            endcase
         end
         OPC_L, OPC_S:      r = a + b;
         OPC_LUI:           r = b & ~LOW12_MASK;
         OPC_AUIPC:         r = a + (b & ~LOW12_MASK);
         OPC_JAL, OPC_JALR: r = a + XLEN'(1);
         default:           r = ZERO_W;
      endcase
      return r;
   endfunction

   state_t              state_r,  state_nx_s;
   logic [CNT_W-1:0]    cnt_r,    cnt_nx_s;
   logic [2*XLEN-1:0]   acc_r,    acc_nx_s;
   logic [XLEN-1:0]     opb_r,    opb_nx_s;
   logic                is_div_r, is_div_nx_s;
   logic                sel_r,    sel_nx_s;
   logic                neg_a_r,  neg_a_nx_s;
   logic                neg_b_r,  neg_b_nx_s;
   logic [XLEN-1:0]     alu_out_r, alu_nx_s;
   logic                non_op_r;
   logic                in_ready_r;
   logic                out_valid_r;
   logic                busy_r;

   logic                accept_s;
   logic                is_m_s;
   logic                m_sgn1_s, m_sgn2_s, m_neg1_s, m_neg2_s;
   logic [XLEN-1:0]     m_mag1_s, m_mag2_s;
   logic                m_special_s;
   logic [XLEN-1:0]     m_special_res_s;

   logic [XLEN:0]       mul_sum_s;
   logic [XLEN:0]       div_sh_s;
   logic [XLEN:0]       div_diff_s;
   logic [2*XLEN-1:0]   step_s;
   logic [2*XLEN-1:0]   prod_s;
   logic [XLEN-1:0]     quo_s, rem_s;
   logic [XLEN-1:0]     final_s;

   // Request decode: signedness, operand magnitudes and the one-cycle M corner cases
   always_comb begin
      accept_s        = bus.in_valid && in_ready_r && !bus.flush;
      is_m_s          = (bus.opcode == OPC_R) && (bus.func7 == F7_MULDIV);
      m_sgn1_s        = !((bus.func3 == 3'b011) || bus.func3[2] && bus.func3[0]);
      m_sgn2_s        = m_sgn1_s && (bus.func3 != 3'b010);
      m_neg1_s        = m_sgn1_s && bus.operand1[XLEN-1];
      m_neg2_s        = m_sgn2_s && bus.operand2[XLEN-1];
      m_mag1_s        = m_neg1_s ? ZERO_W - bus.operand1 : bus.operand1;
      m_mag2_s        = m_neg2_s ? ZERO_W - bus.operand2 : bus.operand2;
      m_special_s     = 1'b0;
      m_special_res_s = ZERO_W;
      if (bus.func3[2] && (bus.operand2 == ZERO_W)) begin
         m_special_s     = 1'b1;
         m_special_res_s = bus.func3[1] ? bus.operand1 : ONES_W;
      end else if (bus.func3[2] && !bus.func3[0] && (bus.operand1 == MIN_W) && (bus.operand2 == ONES_W)) begin
         m_special_s     = 1'b1;
         m_special_res_s = bus.func3[1] ? ZERO_W : bus.operand1;
      end else begin
         m_special_s     = 1'b0;
         m_special_res_s = ZERO_W;
      end
   end

   // One shift-add or restoring-divide step, plus sign fix-up for the final step
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, opb_r};
      div_sh_s   = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
      div_diff_s = div_sh_s - {1'b0, opb_r};
      if (is_div_r) begin
         step_s = div_diff_s[XLEN] ? {div_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0}
                                   : {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
         step_s = acc_r[0] ? {mul_sum_s, acc_r[XLEN-1:1]} : {1'b0, acc_r[2*XLEN-1:1]};
      end
      prod_s = neg_a_r ? {(2*XLEN){1'b0}} - step_s : step_s;
      quo_s  = neg_a_r ? ZERO_W - step_s[XLEN-1:0] : step_s[XLEN-1:0];
      rem_s  = neg_b_r ? ZERO_W - step_s[2*XLEN-1:XLEN] : step_s[2*XLEN-1:XLEN];
      if (is_div_r) begin
         final_s = sel_r ? rem_s : quo_s;
      end else begin
         final_s = sel_r ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
      end
   end

   // FSM next state and datapath load/step selection; flush overrides everything
   always_comb begin
      state_nx_s  = state_r;
      cnt_nx_s    = cnt_r;
      acc_nx_s    = acc_r;
      opb_nx_s    = opb_r;
      is_div_nx_s = is_div_r;
      sel_nx_s    = sel_r;
      neg_a_nx_s  = neg_a_r;
      neg_b_nx_s  = neg_b_r;
      alu_nx_s    = alu_out_r;
      if (bus.flush) begin
         state_nx_s = IDLE;
         cnt_nx_s   = {CNT_W{1'b0}};
         alu_nx_s   = ZERO_W;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s && is_m_s && !m_special_s) begin
                  state_nx_s  = BUSY;
                  cnt_nx_s    = {CNT_W{1'b0}};
                  acc_nx_s    = {ZERO_W, m_mag1_s};
                  opb_nx_s    = m_mag2_s;
                  is_div_nx_s = bus.func3[2];
                  sel_nx_s    = bus.func3[2] ? bus.func3[1] : (bus.func3[1:0] != 2'b00);
                  neg_a_nx_s  = m_neg1_s ^ m_neg2_s;
                  neg_b_nx_s  = m_neg1_s;
               end else if (accept_s) begin
                  state_nx_s = DONE;
                  alu_nx_s   = is_m_s ? m_special_res_s
                                      : base_result(bus.opcode, bus.func3, bus.func7,
                                                    bus.operand1, bus.operand2);
               end else begin
                  state_nx_s = IDLE;
               end
            end
            BUSY: begin
               acc_nx_s = step_s;
               if (cnt_r == CNT_W'(XLEN - 1)) begin
                  state_nx_s = DONE;
                  cnt_nx_s   = {CNT_W{1'b0}};
                  alu_nx_s   = final_s;
               end else begin
                  cnt_nx_s = cnt_r + CNT_W'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_nx_s = IDLE;
               end else begin
                  state_nx_s = DONE;
               end
            end
            default: begin
               state_nx_s = IDLE;
               cnt_nx_s   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         acc_r       <= {(2*XLEN){1'b0}};
         opb_r       <= ZERO_W;
         is_div_r    <= 1'b0;
         sel_r       <= 1'b0;
         neg_a_r     <= 1'b0;
         neg_b_r     <= 1'b0;
         alu_out_r   <= ZERO_W;
         non_op_r    <= 1'b1;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         cnt_r       <= cnt_nx_s;
         acc_r       <= acc_nx_s;
         opb_r       <= opb_nx_s;
         is_div_r    <= is_div_nx_s;
         sel_r       <= sel_nx_s;
         neg_a_r     <= neg_a_nx_s;
         neg_b_r     <= neg_b_nx_s;
         alu_out_r   <= alu_nx_s;
         non_op_r    <= (alu_nx_s == ZERO_W);
         in_ready_r  <= (state_nx_s == IDLE);
         out_valid_r <= (state_nx_s == DONE);
         busy_r      <= (state_nx_s == BUSY);
      end
   end

   assign bus.in_ready      = in_ready_r;
   assign bus.out_valid     = out_valid_r;
   assign bus.busy          = busy_r;
   assign bus.alu_out       = alu_out_r;
   assign bus.non_operation = non_op_r;
endmodule

// File: doc/alu_seq_mext.md
Name: alu_seq_mext

Overview:
- Next-generation execute-stage ALU for the RV32I core.
- Width is parametrised (XLEN). The base integer, branch-compare, load/store-address, LUI/AUIPC/JAL/JALR result computation is kept.
- Adds RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) using iterative multi-cycle datapaths.
- Connects to the pipeline through a valid/ready handshake on input and output. A flush kills in-flight work.

Parameters:
XLEN, 32, datapath width in bits (power of two, >=8)
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  abort current op, discard pending result
in_valid  in  1  request valid
in_ready  out  1  block can accept request
opcode  in  7  RV opcode (OP_I, OP_R, OP_B, OP_L, OP_S, LUI, AUIPC, JAL, JALR)
func3  in  3  RV func3
func7  in  7  RV func7 (0000000 LOGIC/ADD, 0100000 ARITH/SUB, 0000001 MULDIV)
operand1  in  XLEN  rs1 / PC
operand2  in  XLEN  rs2 / immediate
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
alu_out  out  XLEN  result, held stable while out_valid && !out_ready
non_operation  out  1  1 when alu_out == 0
busy  out  1  iterative op in progress

Behaviour:
- Reset (rst_n=0 at posedge) puts the block in state IDLE with outputs out_valid=0, alu_out=0, busy=0, counter=0. Consequently non_operation=1 and in_ready=1.
- Reset mid-operation discards everything.
- FSM states are IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - A request is accepted on a posedge with in_valid && in_ready && !flush. Operands and decode are latched.
- Single-cycle ops go IDLE->DONE. These are all non-M ops, unsupported encodings, and M special cases. out_valid rises the cycle after acceptance (latency 1).
- Base-op semantics, all widths XLEN:
  - Shifts use operand2[$clog2(XLEN)-1:0].
  - SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
  - Branch ops return 1 or 0.
  - Load/store ops return operand1+operand2.
  - LUI returns {operand2[XLEN-1:12],12'b0}.
  - AUIPC returns operand1+{operand2[XLEN-1:12],12'b0}.
  - JAL/JALR return operand1+1.
  - Undefined func3/func7 combinations return 0.
- M ops (opcode OP_R, func7=0000001) go IDLE->BUSY, with busy=1.
  - MUL*: shift-add on |op1|,|op2| magnitudes per signedness (MULHSU: op1 signed, op2 unsigned). 2*XLEN product; the sign is fixed after the last step.
  - DIV*/REM*: restoring radix-2 on magnitudes. Quotient sign = sign1^sign2; remainder sign = sign of dividend.
  - Each takes exactly XLEN BUSY cycles, then DONE. out_valid is asserted XLEN+1 cycles after acceptance.
  - MUL returns product[XLEN-1:0]. MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- M special cases resolve in 1 cycle and never enter BUSY:
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return operand1.
  - Overflow (operand1=-2^(XLEN-1), operand2=-1): DIV returns operand1; REM returns 0.
- DONE: out_valid=1. Advance to IDLE on posedge when out_ready=1.
  - alu_out and non_operation remain stable until then.
  - Back-to-back throughput: the next request can be accepted the cycle after the handshake (1 bubble).
- non_operation is a registered-path equivalent of (alu_out==0). It is valid only when out_valid=1.
- Flush takes effect on the posedge it is high. From any state it goes to IDLE with out_valid=0 and busy=0, and the counter is cleared.
  - A request presented in the same cycle is not accepted.
  - Flush wins over out_ready; a result in DONE is dropped.
- Operand inputs are ignored outside acceptance; changing them during BUSY has no effect.
- No combinational path from in_valid to out_valid.

Test Plan:
1. Reset then ADD (OP_R, func3=000, func7=0): 7+(-3) -> out_valid 1 cycle after accept, alu_out=4, non_operation=0. SUB 5-5 -> alu_out=0, non_operation=1.
2. SRA (OP_I func3=101 func7=0100000): 0x80000000 >>> 4 -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. BGE -1 vs 1 -> 0.
3. MULH: 0x80000000 * 0x80000000 -> 0x40000000 after exactly 33 cycles, busy=1 during 32 cycles. MULHSU(-1, 0xFFFFFFFF) -> 0xFFFFFFFF. MUL 12*-5 -> 0xFFFFFFC4.
4. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF and REMU 7/0 -> 7, both with latency 1. DIV 0x80000000/-1 -> 0x80000000 with latency 1.
5. Backpressure: hold out_ready=0 for 5 cycles after DIV completes -> alu_out stable, in_ready=0. Then assert out_ready -> in_ready=1 next cycle. A new ADD is accepted and its result appears 1 cycle later.
6. Flush at BUSY cycle 10 of DIVU, with in_valid=1 in the same cycle -> out_valid never asserted for the DIVU, that request is not accepted, and in_ready=1 next cycle. Separately, deassert rst_n mid-MUL -> all outputs return to reset values on the next posedge.
